// File: rtl/if_pkg.sv
// Types and constants shared by fetch, the IF/ID buffer and decode.
package if_pkg;

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP_INSTN = 32'h0000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] instn;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] nextpc;
  } if_entry_t;

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry FIFO between fetch and decode; presents a NOP when empty and
// discards everything, including the word on in_*, on a branch flush.
module if_id_buffer #(
  parameter int                DATA_W    = if_pkg::DATA_W,
  parameter logic [DATA_W-1:0] NOP_INSTN = if_pkg::NOP_INSTN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instn,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_nextpc,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instn,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_nextpc,
  output logic [1:0]        count
);

  if_pkg::if_entry_t r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  if_pkg::if_entry_t w_head;

  // in_ready comes from registered occupancy only, so stall never reaches fetch combinationally
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;

  assign w_push = in_valid & in_ready & ~flush;
  assign w_pop  = out_valid & ~stall & ~flush;
  assign w_head = r_mem[r_rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{instn: in_instn, pc: in_pc, nextpc: in_nextpc};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  always_comb begin
    out_instn  = NOP_INSTN;
    out_pc     = '0;
    out_nextpc = '0;
    if (out_valid) begin
      out_instn  = w_head.instn;
      out_pc     = w_head.pc;
      out_nextpc = w_head.nextpc;
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Scoreboard bench for if_id_buffer: a queue models the FIFO contents.
module tb_if_id_buffer;
  import if_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, flush, stall, out_valid;
  logic [DATA_W-1:0] in_instn, in_pc, in_nextpc;
  logic [DATA_W-1:0] out_instn, out_pc, out_nextpc;
  logic [1:0]        count;

  int total = 0;
  int bad   = 0;
  if_entry_t sb[$];

  always #5 clk = ~clk;

  if_id_buffer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instn(in_instn), .in_pc(in_pc), .in_nextpc(in_nextpc),
    .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_instn(out_instn), .out_pc(out_pc),
    .out_nextpc(out_nextpc), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_instn(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  task automatic chk_outs(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(sb.size()));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(sb.size() != 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(sb.size() != 2));
    if (sb.size() != 0) begin
      chk({tag, ".out_pc"}, out_pc, sb[0].pc);
      chk({tag, ".out_instn"}, out_instn, sb[0].instn);
      chk({tag, ".out_nextpc"}, out_nextpc, sb[0].nextpc);
    end else begin
      chk({tag, ".out_pc"}, out_pc, 32'h0);
      chk({tag, ".out_instn"}, out_instn, NOP_INSTN);
      chk({tag, ".out_nextpc"}, out_nextpc, 32'h0);
    end
  endtask

  // One clock: drive, update the model at the edge, check 1ns later.
  task automatic step(input string tag, input logic v, input logic [31:0] pc,
                      input logic s, input logic f, output logic took);
    logic do_push, do_pop;
    in_valid  = v;
    in_pc     = pc;
    in_instn  = mk_instn(pc);
    in_nextpc = pc + 32'd4;
    stall     = s;
    flush     = f;
    do_push = v && (sb.size() != 2) && !f;
    do_pop  = (sb.size() != 0) && !s && !f;
    @(posedge clk);
    if (f) sb.delete();
    else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{instn: mk_instn(pc), pc: pc, nextpc: pc + 32'd4});
    end
    took = do_push;
    #1;
    chk_outs(tag);
  endtask

  initial begin
    logic t;
    logic [31:0] rp;
    reset = 1'b0; in_valid = 1'b0; flush = 1'b0; stall = 1'b0;
    in_instn = '0; in_pc = '0; in_nextpc = '0;
    #3;
    chk_outs("rst_async");
    #9 reset = 1'b1;
    #1 chk_outs("rst_rel");

    // streaming: count holds at 1 while push and pop overlap
    step("st0", 1'b1, 32'h0, 1'b0, 1'b0, t);
    step("st1", 1'b1, 32'h4, 1'b0, 1'b0, t);
    step("st2", 1'b1, 32'h8, 1'b0, 1'b0, t);
    step("st3", 1'b0, 32'h0, 1'b0, 1'b0, t);

    // backpressure: third word must be refused while full and stalled
    step("bp0", 1'b1, 32'h10, 1'b1, 1'b0, t);
    step("bp1", 1'b1, 32'h14, 1'b1, 1'b0, t);
    step("bp2", 1'b1, 32'h18, 1'b1, 1'b0, t);
    chk("bp2.not_taken", 32'(t), 32'd0);
    step("bp3", 1'b1, 32'h18, 1'b1, 1'b0, t);
    step("bp4", 1'b1, 32'h18, 1'b0, 1'b0, t);
    step("bp5", 1'b1, 32'h18, 1'b0, 1'b0, t);
    chk("bp5.taken", 32'(t), 32'd1);
    step("bp6", 1'b0, 32'h0, 1'b0, 1'b0, t);
    step("bp7", 1'b0, 32'h0, 1'b0, 1'b0, t);

    // flush with a concurrent wrong-path word
    step("fl0", 1'b1, 32'h20, 1'b1, 1'b0, t);
    step("fl1", 1'b1, 32'h24, 1'b1, 1'b0, t);
    step("fl2", 1'b1, 32'h28, 1'b0, 1'b1, t);
    step("fl3", 1'b1, 32'h40, 1'b0, 1'b0, t);
    step("fl4", 1'b0, 32'h0, 1'b0, 1'b0, t);

    // flush wins over stall
    step("fs0", 1'b1, 32'h50, 1'b1, 1'b0, t);
    step("fs1", 1'b0, 32'h0, 1'b1, 1'b1, t);

    // random mix; fetch holds a refused word, advances on acceptance
    rp = 32'h100;
    for (int i = 0; i < 60; i++) begin
      step("rnd", 1'(($urandom_range(0, 3)) != 0), rp,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 11) == 0), t);
      if (t) rp = rp + 32'd4;
    end

    // asynchronous reset between edges
    step("ar0", 1'b1, 32'h60, 1'b1, 1'b0, t);
    step("ar1", 1'b1, 32'h64, 1'b1, 1'b0, t);
    in_valid = 1'b0; stall = 1'b0;
    #2 reset = 1'b0;
    sb.delete();
    #1 chk_outs("ar_mid");
    chk("ar_mid.count0", 32'(count), 32'd0);
    @(negedge clk) reset = 1'b1;
    step("ar2", 1'b1, 32'h70, 1'b0, 1'b0, t);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Decoupling stage between instruction fetch and decode. Accepts one fetched word per cycle, together with its PC and next-PC, through a valid/ready handshake. Holds up to two entries in a 2-deep FIFO, so a decode stall never drops a word already in flight from fetch. A branch flush clears the buffer, and a NOP is presented whenever the buffer is empty.

## Interface
- `DATA_W`, 32, width of instruction and PC fields
- `NOP_INSTN`, 32'h0000_0000, word driven on `out_instn` when `out_valid`=0
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  fetch presents a word this cycle
- `in_ready`  out  1  buffer can accept a word this cycle
- `in_instn`  in  DATA_W  fetched instruction
- `in_pc`  in  DATA_W  address of `in_instn`
- `in_nextpc`  in  DATA_W  `in_pc`+4 as computed by fetch
- `flush`  in  1  branch/jump taken in decode; discard all wrong-path words
- `stall`  in  1  decode cannot consume this cycle (hazard unit)
- `out_valid`  out  1  head entry valid
- `out_instn`  out  DATA_W  head instruction
- `out_pc`  out  DATA_W  head PC (feeds branch adder)
- `out_nextpc`  out  DATA_W  head next-PC
- `count`  out  2  occupancy, 0..2

## Operation
- Storage: two entries (instn, pc, nextpc). Separate 1-bit write pointer and 1-bit read pointer, plus a 2-bit `count`.
- Push: `push = in_valid & in_ready & ~flush`.
- Pop: `pop = out_valid & ~stall & ~flush`.
- `in_ready = (count != 2)`. It depends only on registered state, with no combinational path from `stall`.
- `out_valid = (count != 0)`.
- With `out_valid`=1, the outputs show the read-pointer entry.
- With `out_valid`=0, the outputs are `out_instn`=`NOP_INSTN`, `out_pc`=0, `out_nextpc`=0.
- Count update per cycle:
  - push & ~pop: +1
  - pop & ~push: −1
  - both or neither: unchanged
- Flush has absolute priority. In the clock edge where `flush`=1:
  - count←0
  - both pointers←0
  - the word on `in_*` in that same cycle is discarded, since it is wrong-path
  - entry data need not be cleared
- `stall`=1 holds the head and its outputs stable. Pushes continue until full.
- `in_valid` while `in_ready`=0: the word is not taken. Fetch must hold it; the buffer does not sample it.
- Pointer wrap: 1-bit pointers wrap naturally, 1→0.
- Arithmetic: no arithmetic on the PC fields; they are passed through unchanged.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert by the system):
  - `count`=0, pointers=0
  - `out_valid`=0, `out_instn`=`NOP_INSTN`, `out_pc`=0, `out_nextpc`=0
  - `in_ready`=1
- Latency: a word pushed at edge N appears on `out_*` with `out_valid`=1 after edge N. There is no same-cycle bypass from `in_*` to `out_*`.
- Throughput: 1 word/cycle sustained with `stall`=0 and count at 1, since push and pop happen together.
- Full (count=2) with `stall`=0: pop only, so count→1 and `in_ready`=1 next cycle.
- Full with `stall`=1: state frozen.
- Empty with `in_valid`=1 and `stall`=1: the push proceeds, count→1.
- `flush` and `stall` together: flush wins, count→0.
- Reset mid-operation: all entries are lost immediately (asynchronous). Outputs return to their reset values without waiting for a clock edge.

## Structure
- Shared package `if_pkg`:
  - `DATA_W` default
  - `NOP_INSTN` constant
  - `if_entry_t` packed struct {instn, pc, nextpc}, shared with the fetch and decode stages
- Single module; no sub-module. Storage is a 2-element array of `if_entry_t` plus pointer/count logic in one always block. Output muxing is combinational.

## Test plan
- Reset check: `reset`=0 then 1 → `count`=0, `out_valid`=0, `out_instn`=0x00000000, `in_ready`=1.
- Streaming: push pc=0,4,8 on consecutive cycles with `stall`=0 → `out_pc`=0,4,8 one cycle later each, `count` stays 1, `in_ready` stays 1.
- Backpressure: hold `stall`=1 and push pc=0x10, 0x14, 0x18 → `count`=2, `in_ready`=0, `out_pc`=0x10 stable, 0x18 not taken. Release `stall` → `out_pc` sequence 0x10, 0x14, 0x18 with nothing lost or duplicated.
- Flush: `count`=2 holding pc 0x20 and 0x24; assert `flush`=1 together with `in_valid`=1 on pc 0x28 → next cycle `count`=0, `out_valid`=0, `out_instn`=NOP. The next push, pc=0x40, appears as the head.
- Flush+stall: `count`=1 with `stall`=1 and `flush`=1 → `count`=0 next cycle.
- Asynchronous reset mid-stream: `count`=2, drop `reset` between clock edges → `out_valid`=0 and `count`=0 before the next edge.
